// File: rtl/gen_scheduler.sv
// rtl/gen_scheduler.sv - Game of Life generation scheduler (optional stats via GEN_STATS_EN)
module gen_scheduler #(
    parameter int LOG_MAX_SPEED       = 5,
    parameter int LOG_NUM_SEED        = 5,
    parameter int GRAPH_SAMPLE_PERIOD = 2,
    parameter int GEN_COUNT_W         = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     step_in,
    input  logic                     seed_en_in,
    input  logic [LOG_NUM_SEED-1:0]  seed_in,
    input  logic                     vsync_in,
    output logic                     gen_start_out,
    input  logic                     gen_done_in,
    output logic                     seed_start_out,
    output logic [LOG_NUM_SEED-1:0]  seed_id_out,
    input  logic                     seed_done_in,
    output logic                     buf_swap_out,
    output logic                     busy_out,
    output logic [GEN_COUNT_W-1:0]   gen_count_out,
    output logic                     stats_sample_out
);

    localparam int MAX_SPEED = 2 ** LOG_MAX_SPEED;

    typedef enum logic [1:0] {IDLE, SEED, GEN, SWAP_WAIT} state_t;

    state_t                   r_state;
    logic                     r_vsync;
    logic                     r_seed_en_d;
    logic                     r_seed_pend;
    logic                     r_step_pend;
    logic [LOG_NUM_SEED-1:0]  r_seed_req;
    logic [LOG_MAX_SPEED-1:0] r_frame_cnt;
    logic                     r_gen_start;
    logic                     r_seed_start;
    logic                     r_buf_swap;
    logic                     r_busy;
    logic [LOG_NUM_SEED-1:0]  r_seed_id;

    logic                     w_frame_edge;
    logic                     w_seed_rise;
    logic [LOG_MAX_SPEED:0]   w_threshold;
    logic                     w_go_seed;
    logic                     w_go_step;
    logic                     w_go_speed;
    logic                     w_go_gen;
    logic                     w_gen_done;
    logic                     w_seed_done;

    assign w_frame_edge = r_vsync & ~vsync_in;
    assign w_seed_rise  = seed_en_in & ~r_seed_en_d;
    assign w_threshold  = (LOG_MAX_SPEED+1)'(MAX_SPEED) - {1'b0, speed_in};

    // Seed beats step beats free-running speed; all only from IDLE
    assign w_go_seed  = (r_state == IDLE) && r_seed_pend;
    assign w_go_step  = (r_state == IDLE) && !r_seed_pend && (speed_in == '0) && r_step_pend;
    assign w_go_speed = (r_state == IDLE) && !r_seed_pend && (speed_in != '0)
                        && ({1'b0, r_frame_cnt} >= w_threshold);
    assign w_go_gen   = w_go_step || w_go_speed;

    // A done pulse on the start cycle belongs to no launch of ours, so it is dropped
    assign w_gen_done  = (r_state == GEN)  && gen_done_in  && !r_gen_start;
    assign w_seed_done = (r_state == SEED) && seed_done_in && !r_seed_start;

    assign gen_start_out  = r_gen_start;
    assign seed_start_out = r_seed_start;
    assign seed_id_out    = r_seed_id;
    assign buf_swap_out   = r_buf_swap;
    assign busy_out       = r_busy;

    // Edge detectors, request latches and the frame counter
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vsync     <= 1'b1;
            r_seed_en_d <= 1'b0;
            r_seed_pend <= 1'b0;
            r_step_pend <= 1'b0;
            r_seed_req  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_vsync     <= vsync_in;
            r_seed_en_d <= seed_en_in;
            if (w_seed_rise) begin
                r_seed_pend <= 1'b1;
                r_seed_req  <= seed_in;
            end else if (w_go_seed) begin
                r_seed_pend <= 1'b0;
            end
            if (step_in && (speed_in == '0)) begin
                r_step_pend <= 1'b1;
            end else if (w_go_step) begin
                r_step_pend <= 1'b0;
            end
            if (w_go_seed || w_go_gen) begin
                r_frame_cnt <= '0;
            end else if (w_frame_edge && (r_frame_cnt != {LOG_MAX_SPEED{1'b1}})) begin
                r_frame_cnt <= r_frame_cnt + LOG_MAX_SPEED'(1);
            end
        end
    end

    // Scheduler FSM with registered pulse outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_gen_start  <= 1'b0;
            r_seed_start <= 1'b0;
            r_buf_swap   <= 1'b0;
            r_busy       <= 1'b0;
            r_seed_id    <= '0;
        end else begin
            r_gen_start  <= 1'b0;
            r_seed_start <= 1'b0;
            r_buf_swap   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go_seed) begin
                        r_state      <= SEED;
                        r_seed_start <= 1'b1;
                        r_seed_id    <= r_seed_req;
                        r_busy       <= 1'b1;
                    end else if (w_go_gen) begin
                        r_state     <= GEN;
                        r_gen_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SEED: begin
                    if (w_seed_done) r_state <= SWAP_WAIT;
                end
                GEN: begin
                    if (w_gen_done) r_state <= SWAP_WAIT;
                end
                SWAP_WAIT: begin
                    if (w_frame_edge) begin
                        r_state    <= IDLE;
                        r_buf_swap <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GEN_STATS_EN
    localparam int SAMPLE_W = (GRAPH_SAMPLE_PERIOD > 1) ? $clog2(GRAPH_SAMPLE_PERIOD) : 1;

    logic [GEN_COUNT_W-1:0] r_gen_count;
    logic [SAMPLE_W-1:0]    r_sample_cnt;
    logic                   r_stats;

    assign gen_count_out    = r_gen_count;
    assign stats_sample_out = r_stats;

    // Generation counter cleared by seed loads; sample strobe every period
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_gen_count  <= '0;
            r_sample_cnt <= '0;
            r_stats      <= 1'b0;
        end else begin
            r_stats <= 1'b0;
            if (w_seed_done) begin
                r_gen_count <= '0;
            end else if (w_gen_done) begin
                r_gen_count <= r_gen_count + GEN_COUNT_W'(1);
                if (r_sample_cnt == SAMPLE_W'(GRAPH_SAMPLE_PERIOD - 1)) begin
                    r_sample_cnt <= '0;
                    r_stats      <= 1'b1;
                end else begin
                    r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
                end
            end
        end
    end
`else
    assign gen_count_out    = '0;
    assign stats_sample_out = 1'b0;
`endif

endmodule

// File: tb/tb_gen_scheduler.sv
// tb/tb_gen_scheduler.sv - directed scoreboard bench for gen_scheduler
module tb_gen_scheduler;

    localparam int FRAME = 200;
    localparam int W_GS = 0, W_SS = 1, W_SW = 2;
`ifdef GEN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [4:0]  speed_in = '0;
    logic        step_in = 1'b0;
    logic        seed_en_in = 1'b0;
    logic [4:0]  seed_in = '0;
    logic        vsync_in;
    logic        gen_start_out;
    logic        gen_done_in;
    logic        gd_auto, gd_man;
    logic        seed_start_out;
    logic [4:0]  seed_id_out;
    logic        seed_done_in;
    logic        buf_swap_out;
    logic        busy_out;
    logic [15:0] gen_count_out;
    logic        stats_sample_out;

    int  n_tests = 0, n_fail = 0;
    int  n_frames = 0, n_gs = 0, n_sw = 0;
    bit  vs_run = 1'b0, auto_gen = 1'b1, saw_stats;
    int  exp_cnt_q[$];
    bit  exp_samp_q[$];
    int  exp_seed_q[$];

    assign gen_done_in = gd_auto | gd_man;

    gen_scheduler dut (
        .clk_in(clk), .rst_in(rst_in), .speed_in(speed_in), .step_in(step_in),
        .seed_en_in(seed_en_in), .seed_in(seed_in), .vsync_in(vsync_in),
        .gen_start_out(gen_start_out), .gen_done_in(gen_done_in),
        .seed_start_out(seed_start_out), .seed_id_out(seed_id_out),
        .seed_done_in(seed_done_in), .buf_swap_out(buf_swap_out), .busy_out(busy_out),
        .gen_count_out(gen_count_out), .stats_sample_out(stats_sample_out)
    );

    always #5 clk = ~clk;

    // Frame generator: vsync low for the last 4 cycles of each frame
    initial begin
        int ctr;
        ctr = 0;
        vsync_in = 1'b1;
        forever begin
            @(negedge clk);
            if (!vs_run) begin
                vsync_in = 1'b1;
                ctr = 0;
            end else begin
                ctr++;
                if (ctr == FRAME - 4) begin
                    vsync_in = 1'b0;
                    n_frames++;
                end else if (ctr >= FRAME) begin
                    vsync_in = 1'b1;
                    ctr = 0;
                end
            end
        end
    end

    // Engine model: completion 100 cycles after each start
    initial begin
        gd_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_gen && gen_start_out) begin
                repeat (100) @(negedge clk);
                gd_auto = 1'b1;
                @(negedge clk);
                gd_auto = 1'b0;
            end
        end
    end

    // Seed loader model: completion 20 cycles after each start
    initial begin
        seed_done_in = 1'b0;
        forever begin
            @(negedge clk);
            if (seed_start_out) begin
                repeat (20) @(negedge clk);
                seed_done_in = 1'b1;
                @(negedge clk);
                seed_done_in = 1'b0;
            end
        end
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (gen_start_out) n_gs++;
        if (buf_swap_out) n_sw++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            W_GS:    return gen_start_out;
            W_SS:    return seed_start_out;
            default: return buf_swap_out;
        endcase
    endfunction

    task automatic wait_for(input int which, input int max_cyc, output bit ok);
        ok = 1'b0;
        saw_stats = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (stats_sample_out) saw_stats = 1'b1;
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_step();
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
    endtask

    initial begin
        bit ok;
        int base, ec;
        bit es;
        gd_man = 1'b0;
        repeat (3) tick();
        check("reset_pulses", {29'd0, gen_start_out, seed_start_out, buf_swap_out}, 32'd0);
        rst_in = 1'b0;
        tick();
        check("reset_busy_stats", {30'd0, busy_out, stats_sample_out}, 32'd0);
        check("reset_count", {16'd0, gen_count_out}, 32'd0);
        check("reset_seed_id", {27'd0, seed_id_out}, 32'd0);

        // Free-running at top speed: one generation per frame
        speed_in = 5'd31;
        vs_run = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            if (g == 1) begin
                wait_for(W_GS, 2 * FRAME, ok);
                check("first_start", {31'd0, ok}, 32'd1);
            end else begin
                tick();
                check("back_to_back_start", {31'd0, gen_start_out}, 32'd1);
            end
            exp_cnt_q.push_back(STATS ? g : 0);
            exp_samp_q.push_back(STATS && (g % 2 == 0));
            if (g == 4) speed_in = 5'd0;
            wait_for(W_SW, 2 * FRAME, ok);
            check("swap_after_gen", {31'd0, ok}, 32'd1);
            ec = exp_cnt_q.pop_front();
            es = exp_samp_q.pop_front();
            check("gen_count", {16'd0, gen_count_out}, ec);
            check("stats_sample", {31'd0, saw_stats}, {31'd0, es});
        end

        // Paused: one step gives exactly one generation
        tick();
        check("idle_after_pause", {31'd0, busy_out}, 32'd0);
        pulse_step();
        wait_for(W_GS, 10, ok);
        check("step_start", {31'd0, ok}, 32'd1);
        wait_for(W_SW, 2 * FRAME, ok);
        check("step_swap", {31'd0, ok}, 32'd1);
        base = n_gs;
        repeat (3 * FRAME) tick();
        check("paused_no_start", n_gs - base, 32'd0);
        speed_in = 5'd16;
        pulse_step();
        repeat (20) tick();
        speed_in = 5'd0;
        repeat (10) tick();
        check("step_discarded", n_gs - base, 32'd0);

        // Speed change lowers threshold below current frame count
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        speed_in = 5'd16;
        base = n_frames;
        for (int i = 0; i < 6 * FRAME && n_frames < base + 5; i++) tick();
        check("five_frames_seen", {31'd0, (n_frames >= base + 5)}, 32'd1);
        repeat (5) tick();
        base = n_gs;
        check("no_launch_at_16", {31'd0, busy_out}, 32'd0);
        speed_in = 5'd30;
        repeat (3) tick();
        check("launch_after_speed_change", n_gs - base, 32'd1);
        speed_in = 5'd0;
        wait_for(W_SW, 2 * FRAME, ok);
        check("speed_change_swap", {31'd0, ok}, 32'd1);

        // Seed request arriving during GEN
        pulse_step();
        wait_for(W_GS, 10, ok);
        check("gen_before_seed", {31'd0, ok}, 32'd1);
        repeat (10) tick();
        seed_in = 5'd7;
        seed_en_in = 1'b1;
        exp_seed_q.push_back(7);
        tick();
        seed_in = 5'd9;
        repeat (5) tick();
        seed_en_in = 1'b0;
        wait_for(W_SW, 2 * FRAME, ok);
        check("swap_before_seed", {31'd0, ok}, 32'd1);
        check("count_before_seed", {16'd0, gen_count_out}, STATS ? 32'd2 : 32'd0);
        wait_for(W_SS, 5, ok);
        check("seed_start", {31'd0, ok}, 32'd1);
        ec = exp_seed_q.pop_front();
        check("seed_id", {27'd0, seed_id_out}, ec);
        wait_for(W_SW, 2 * FRAME, ok);
        check("seed_swap", {31'd0, ok}, 32'd1);
        check("seed_id_held", {27'd0, seed_id_out}, ec);
        check("count_after_seed", {16'd0, gen_count_out}, 32'd0);

        // Done coincident with start is ignored
        auto_gen = 1'b0;
        pulse_step();
        wait_for(W_GS, 10, ok);
        check("coinc_start", {31'd0, ok}, 32'd1);
        gd_man = 1'b1;
        tick();
        gd_man = 1'b0;
        base = n_sw;
        repeat (FRAME + 20) tick();
        check("coinc_no_swap", n_sw - base, 32'd0);
        check("coinc_still_busy", {31'd0, busy_out}, 32'd1);
        gd_man = 1'b1;
        tick();
        gd_man = 1'b0;
        wait_for(W_SW, 2 * FRAME, ok);
        check("coinc_later_done", {31'd0, ok}, 32'd1);

        // Reset while waiting for the swap
        auto_gen = 1'b1;
        vs_run = 1'b0;
        pulse_step();
        wait_for(W_GS, 10, ok);
        check("rst_test_start", {31'd0, ok}, 32'd1);
        repeat (120) tick();
        check("in_swap_wait", {31'd0, busy_out}, 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst_pulses", {27'd0, busy_out, gen_start_out, seed_start_out, buf_swap_out, stats_sample_out}, 32'd0);
        check("rst_count", {16'd0, gen_count_out}, 32'd0);
        check("rst_seed_id", {27'd0, seed_id_out}, 32'd0);
        vs_run = 1'b1;
        base = n_sw;
        repeat (2 * FRAME) tick();
        check("rst_no_swap", n_sw - base, 32'd0);
        check("rst_idle", {31'd0, busy_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_scheduler.md
# gen_scheduler

Generation scheduler for the Game of Life core. It sits between user-input decoding and the life engine. It converts the speed setting, single-step and seed-load requests into start pulses for the engine, and waits for each engine completion. Buffer swaps are released only on a VGA frame boundary, so the display never shows a half-updated board. It also produces generation-count and sample strobes for the statistics graph.

## Interface
Parameters:
- LOG_MAX_SPEED, 5, width of speed_in; MAX_SPEED = 2**LOG_MAX_SPEED
- LOG_NUM_SEED, 5, width of seed index
- GRAPH_SAMPLE_PERIOD, 2, generations between stats_sample_out strobes
- GEN_COUNT_W, 16, width of generation counter

Ports:
- clk_in  in  1  system clock; one clock domain
- rst_in  in  1  reset; synchronous, active-high
- speed_in  in  LOG_MAX_SPEED  0 = paused; otherwise one generation every (MAX_SPEED - speed_in) frames
- step_in  in  1  single-step pulse, honoured only while paused
- seed_en_in  in  1  seed-load request, level; acted on at its rising edge
- seed_in  in  LOG_NUM_SEED  seed index, sampled at the seed_en_in rising edge
- vsync_in  in  1  VGA vsync, active-low; its falling edge marks the frame boundary
- gen_start_out  out  1  one-cycle pulse to launch one engine generation
- gen_done_in  in  1  one-cycle engine completion pulse
- seed_start_out  out  1  one-cycle pulse to launch a seed load
- seed_id_out  out  LOG_NUM_SEED  seed index; held stable from seed_start_out until seed_done_in
- seed_done_in  in  1  one-cycle seed-load completion pulse
- buf_swap_out  out  1  one-cycle pulse to swap display and compute buffers
- busy_out  out  1  high in every state except IDLE
- gen_count_out  out  GEN_COUNT_W  generations since the last seed; wraps at the top of its range
- stats_sample_out  out  1  one-cycle strobe every GRAPH_SAMPLE_PERIOD generations

## Operation
- Frame edge: a registered copy of vsync_in is kept. frame_edge = (previous value 1) and (current value 0).
- frame_cnt:
  - LOG_MAX_SPEED bits.
  - Increments on every frame_edge in every state, saturating at MAX_SPEED-1.
  - Cleared to 0 on every launch, both generation and seed.
- States: IDLE, SEED, GEN, SWAP_WAIT.
- IDLE launch priority, highest first:
  1. A pending seed request: go to SEED.
  2. speed_in==0 and a pending step: go to GEN.
  3. speed_in!=0 and frame_cnt >= MAX_SPEED - speed_in: go to GEN.
  - If none of these holds, stay in IDLE.
- Request latches:
  - Seed and step requests are latched in single-entry pending flags, in any state.
  - Each flag is cleared when its launch is taken.
  - A step arriving while speed_in!=0 is discarded.
  - A second request of the same kind while one is pending is merged into it.
  - The seed index is latched at the seed_en_in rising edge; the latest edge wins.
- SEED:
  - seed_start_out is high on the entry cycle only.
  - The block waits for seed_done_in, then goes to SWAP_WAIT.
  - gen_count_out is cleared to 0 when seed_done_in arrives.
- GEN:
  - gen_start_out is high on the entry cycle only.
  - The block waits for gen_done_in, then goes to SWAP_WAIT.
  - gen_count_out increments when gen_done_in arrives.
  - A sample counter runs from 0 to GRAPH_SAMPLE_PERIOD-1. When it wraps, stats_sample_out pulses in the cycle after gen_done_in.
- SWAP_WAIT: on frame_edge, buf_swap_out pulses for one cycle and the state returns to IDLE.
- Done pulses that arrive outside their own wait state are ignored. This includes a done pulse that coincides with the start cycle.

## Timing
- All outputs are registered.
- Reset values:
  - All pulse outputs are 0.
  - busy_out = 0 and state = IDLE.
  - gen_count_out = 0, frame_cnt = 0, pending flags = 0, seed_id_out = 0, sample counter = 0.
  - The vsync register resets to 1, so reset itself does not create a false frame edge.
- Launch: the condition is true at cycle t; start pulse and busy_out=1 at t+1.
- Completion: done pulse at t; state SWAP_WAIT at t+1.
- Swap: frame_edge detected at t; buf_swap_out=1 at t+1 and state IDLE at t+1. Launch for the next generation is possible at t+2.
- Because frame_cnt counts the swap edge, speed_in = MAX_SPEED-1 sustains one generation per frame when the engine finishes within one frame.
- A speed change takes effect at the next IDLE evaluation. Lowering the threshold below frame_cnt launches immediately.
- rst_in mid-operation: the block returns to IDLE at the next edge. In-flight done pulses are then ignored, and no swap is issued.

## Configuration
- GEN_STATS_EN
  - Defined: gen_count_out, the sample counter and stats_sample_out are implemented as described above.
  - Undefined: the counters are removed, gen_count_out is tied to 0 and stats_sample_out is tied to 0. Scheduling behaviour is identical in both cases.

## Test plan
- Reset, then speed_in=31, vsync toggling, done returned 100 cycles after each start: one gen_start_out per frame; buf_swap_out on each following frame edge; gen_count_out reaches 4 after 4 generations; stats_sample_out pulses after generations 2 and 4.
- speed_in=0, step_in pulsed once and held off: exactly one gen_start_out, then idle indefinitely. A step pulsed while speed_in=16 produces no start.
- seed_en_in rises with seed_in=7 during GEN: after gen_done_in and the swap, seed_start_out fires with seed_id_out=7; gen_count_out=0 after seed_done_in.
- speed_in=16 (period 16 frames), changed to 30 after 5 frames in IDLE: launch at the next IDLE evaluation, since 5 >= 2.
- gen_done_in coincident with gen_start_out: ignored; the block stays in GEN until a later gen_done_in.
- rst_in asserted in SWAP_WAIT: no buf_swap_out; all outputs at reset values the next cycle.
